// File: rtl/controlador_microondas.sv
// controlador_microondas: central sequencer of the microwave oven.
// The controller does the following:
//   - captures BCD key digits into an MM:SS time register
//   - runs the cook countdown from a 1 Hz pulse
//   - drives the magnetron
//   - handles the door, start, stop and clear events
//
// Ports:
//   clk100Hz      in   100 Hz system clock, rising edge
//   resetn        in   asynchronous reset, active-low
//   digito[3:0]   in   BCD digit from the keypad encoder
//   loadn         in   encoder key-valid, active-low level
//   pgt_1Hz       in   1 Hz pulse (tick = 0->1 transition)
//   startn        in   start button, active-low level
//   stopn         in   stop/pause button, active-low level
//   clearn        in   clear button, active-low level
//   porta_fechada in   1 = door closed
//   enablen       out  encoder enable, active-low (low in IDLE/ENTRY)
//   min_dez/min_uni/seg_dez/seg_uni  out  BCD time digits MM:SS
//   magnetron     out  1 = heating
//   done          out  cook-finished indicator
//   estado[2:0]   out  IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4
module controlador_microondas #(
  parameter int unsigned DONE_CYCLES   = 300,
  parameter int unsigned QUICK_SEC_DEZ = 3
) (
  input  logic       clk100Hz,
  input  logic       resetn,
  input  logic [3:0] digito,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       porta_fechada,
  output logic       enablen,
  output logic [3:0] min_dez,
  output logic [3:0] min_uni,
  output logic [3:0] seg_dez,
  output logic [3:0] seg_uni,
  output logic       magnetron,
  output logic       done,
  output logic [2:0] estado
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ENTRY = 3'd1;
  localparam logic [2:0] COOK  = 3'd2;
  localparam logic [2:0] PAUSE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int unsigned CNT_W = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  logic [2:0]       r_state;
  logic [15:0]      r_time;  // {min_dez, min_uni, seg_dez, seg_uni}
  logic [CNT_W-1:0] r_cnt;
  logic             r_magnetron;
  logic             r_done;
  logic             r_enablen;
  logic             r_loadn;
  logic             r_startn;
  logic             r_stopn;
  logic             r_clearn;
  logic             r_pgt;

  logic [2:0]       w_state_d;
  logic [15:0]      w_time_d;
  logic [15:0]      w_time_dec;
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_key;
  logic             w_start;
  logic             w_stop;
  logic             w_clear;
  logic             w_tick;

  // Events compare the previous sample with the current level, so each press
  // produces exactly one event on the first edge that sees it.
  assign w_key   = r_loadn  & ~loadn;
  assign w_start = r_startn & ~startn;
  assign w_stop  = r_stopn  & ~stopn;
  assign w_clear = r_clearn & ~clearn;
  assign w_tick  = ~r_pgt   & pgt_1Hz;

  // One-second BCD decrement; 00:00 stays put.
  always_comb begin
    w_time_dec = r_time;
    if (r_time[3:0] != 4'd0) begin
      w_time_dec[3:0] = r_time[3:0] - 4'd1;
    end else if (r_time[7:4] != 4'd0) begin
      w_time_dec[7:4] = r_time[7:4] - 4'd1;
      w_time_dec[3:0] = 4'd9;
    end else if (r_time[11:8] != 4'd0) begin
      w_time_dec[11:8] = r_time[11:8] - 4'd1;
      w_time_dec[7:0]  = 8'h59;
    end else if (r_time[15:12] != 4'd0) begin
      w_time_dec[15:12] = r_time[15:12] - 4'd1;
      w_time_dec[11:8]  = 4'd9;
      w_time_dec[7:0]   = 8'h59;
    end
  end

  // Event priority: clear > stop > door open > start > key > tick.
  always_comb begin
    w_state_d = r_state;
    w_time_d  = r_time;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      IDLE, ENTRY: begin
        if (w_clear) begin
          w_state_d = IDLE;
          w_time_d  = 16'h0000;
        end else if (w_stop) begin
          w_state_d = r_state;
        end else if (w_start) begin
          if (porta_fechada) begin
            if (r_time != 16'h0000) begin
              w_state_d = COOK;
            end else if (r_state == IDLE) begin
              w_time_d  = {8'h00, 4'(QUICK_SEC_DEZ), 4'h0};
              w_state_d = COOK;
            end
          end
        end else if (w_key && (digito <= 4'd9)) begin
          w_time_d  = {r_time[11:0], digito};
          w_state_d = ENTRY;
        end
      end
      COOK: begin
        if (w_clear || w_stop || !porta_fechada) begin
          w_state_d = PAUSE;
        end else if (w_start || w_key) begin
          w_state_d = COOK;
        end else if (w_tick) begin
          w_time_d = w_time_dec;
          if (w_time_dec == 16'h0000) begin
            w_state_d = DONE;
            w_cnt_d   = '0;
          end
        end
      end
      PAUSE: begin
        if (w_clear || w_stop) begin
          w_state_d = IDLE;
          w_time_d  = 16'h0000;
        end else if (w_start && porta_fechada) begin
          w_state_d = COOK;
        end
      end
      DONE: begin
        w_time_d = 16'h0000;
        if (w_clear || w_stop || w_start) begin
          w_state_d = IDLE;
          w_cnt_d   = '0;
        end else if (r_cnt == CNT_W'(DONE_CYCLES - 1)) begin
          w_state_d = IDLE;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_d = IDLE;
        w_time_d  = 16'h0000;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk100Hz or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_time      <= 16'h0000;
      r_cnt       <= '0;
      r_magnetron <= 1'b0;
      r_done      <= 1'b0;
      r_enablen   <= 1'b0;
      r_loadn     <= 1'b1;
      r_startn    <= 1'b1;
      r_stopn     <= 1'b1;
      r_clearn    <= 1'b1;
      r_pgt       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_time      <= w_time_d;
      r_cnt       <= w_cnt_d;
      // Outputs are registered alongside the state so they switch on the same edge.
      r_magnetron <= (w_state_d == COOK);
      r_done      <= (w_state_d == DONE);
      r_enablen   <= (w_state_d != IDLE) && (w_state_d != ENTRY);
      r_loadn     <= loadn;
      r_startn    <= startn;
      r_stopn     <= stopn;
      r_clearn    <= clearn;
      r_pgt       <= pgt_1Hz;
    end
  end

  assign estado    = r_state;
  assign min_dez   = r_time[15:12];
  assign min_uni   = r_time[11:8];
  assign seg_dez   = r_time[7:4];
  assign seg_uni   = r_time[3:0];
  assign magnetron = r_magnetron;
  assign done      = r_done;
  assign enablen   = r_enablen;

endmodule

// File: tb/tb_controlador_microondas.sv
module tb_controlador_microondas;

  logic       clk100Hz = 1'b0;
  logic       resetn;
  logic [3:0] digito;
  logic       loadn;
  logic       pgt_1Hz;
  logic       startn;
  logic       stopn;
  logic       clearn;
  logic       porta_fechada;
  logic       enablen;
  logic [3:0] min_dez;
  logic [3:0] min_uni;
  logic [3:0] seg_dez;
  logic [3:0] seg_uni;
  logic       magnetron;
  logic       done;
  logic [2:0] estado;

  int n_checks = 0;
  int n_fail   = 0;

  controlador_microondas #(
    .DONE_CYCLES  (300),
    .QUICK_SEC_DEZ(3)
  ) dut (
    .clk100Hz     (clk100Hz),
    .resetn       (resetn),
    .digito       (digito),
    .loadn        (loadn),
    .pgt_1Hz      (pgt_1Hz),
    .startn       (startn),
    .stopn        (stopn),
    .clearn       (clearn),
    .porta_fechada(porta_fechada),
    .enablen      (enablen),
    .min_dez      (min_dez),
    .min_uni      (min_uni),
    .seg_dez      (seg_dez),
    .seg_uni      (seg_uni),
    .magnetron    (magnetron),
    .done         (done),
    .estado       (estado)
  );

  always #5 clk100Hz = ~clk100Hz;

  wire [15:0] w_time = {min_dez, min_uni, seg_dez, seg_uni};

  // Button index: 0 start, 1 stop, 2 clear.
  task automatic press(input int b);
    @(negedge clk100Hz);
    case (b)
      0: startn = 1'b0;
      1: stopn  = 1'b0;
      default: clearn = 1'b0;
    endcase
    @(negedge clk100Hz);
    startn = 1'b1;
    stopn  = 1'b1;
    clearn = 1'b1;
    @(negedge clk100Hz);
  endtask

  task automatic key(input logic [3:0] d);
    @(negedge clk100Hz);
    digito = d;
    loadn  = 1'b0;
    @(negedge clk100Hz);
    loadn = 1'b1;
    @(negedge clk100Hz);
  endtask

  task automatic tick();
    @(negedge clk100Hz);
    pgt_1Hz = 1'b1;
    @(negedge clk100Hz);
    pgt_1Hz = 1'b0;
    @(negedge clk100Hz);
  endtask

  task automatic do_reset();
    @(negedge clk100Hz);
    resetn = 1'b0;
    repeat (2) @(negedge clk100Hz);
    resetn = 1'b1;
    @(negedge clk100Hz);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (estado !== 3'd0) begin
      n_fail++; $display("FAIL reset_estado got %0d want 0", estado);
    end
    n_checks++;
    if (w_time !== 16'h0000) begin
      n_fail++; $display("FAIL reset_time got %h want 0000", w_time);
    end
    n_checks++;
    if ({enablen, magnetron, done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_outputs got %b want 000", {enablen, magnetron, done});
    end
  endtask

  task automatic test_entry();
    do_reset();
    key(4'd1); key(4'd2); key(4'd3);
    n_checks++;
    if (w_time !== 16'h0123) begin
      n_fail++; $display("FAIL entry_time got %h want 0123", w_time);
    end
    n_checks++;
    if (estado !== 3'd1 || enablen !== 1'b0) begin
      n_fail++; $display("FAIL entry_state got %0d/%b want 1/0", estado, enablen);
    end
  endtask

  task automatic test_cook_done();
    do_reset();
    key(4'd0); key(4'd5);
    press(0);
    n_checks++;
    if (estado !== 3'd2 || magnetron !== 1'b1 || enablen !== 1'b1) begin
      n_fail++; $display("FAIL cook_start got %0d/%b/%b want 2/1/1", estado, magnetron, enablen);
    end
    repeat (4) tick();
    n_checks++;
    if (w_time !== 16'h0001) begin
      n_fail++; $display("FAIL cook_count got %h want 0001", w_time);
    end
    tick();
    n_checks++;
    if (w_time !== 16'h0000 || estado !== 3'd4 || done !== 1'b1 || magnetron !== 1'b0) begin
      n_fail++;
      $display("FAIL cook_done got %h/%0d/%b/%b want 0000/4/1/0", w_time, estado, done, magnetron);
    end
    repeat (290) @(negedge clk100Hz);
    n_checks++;
    if (estado !== 3'd4 || done !== 1'b1) begin
      n_fail++; $display("FAIL done_hold got %0d/%b want 4/1", estado, done);
    end
    repeat (15) @(negedge clk100Hz);
    n_checks++;
    if (estado !== 3'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL done_expire got %0d/%b want 0/0", estado, done);
    end
  endtask

  task automatic test_borrow();
    do_reset();
    key(4'd1); key(4'd0); key(4'd0);
    press(0);
    tick();
    n_checks++;
    if (w_time !== 16'h0059) begin
      n_fail++; $display("FAIL borrow_min got %h want 0059", w_time);
    end
    press(2);
    press(2);
    n_checks++;
    if (estado !== 3'd0 || w_time !== 16'h0000) begin
      n_fail++; $display("FAIL pause_clear got %0d/%h want 0/0000", estado, w_time);
    end
    key(4'd9); key(4'd9);
    press(0);
    tick();
    n_checks++;
    if (w_time !== 16'h0098 || estado !== 3'd2) begin
      n_fail++; $display("FAIL borrow_99 got %h/%0d want 0098/2", w_time, estado);
    end
  endtask

  task automatic test_door();
    do_reset();
    key(4'd4); key(4'd2);
    press(0);
    @(negedge clk100Hz);
    porta_fechada = 1'b0;
    @(negedge clk100Hz);
    n_checks++;
    if (estado !== 3'd3 || magnetron !== 1'b0) begin
      n_fail++; $display("FAIL door_pause got %0d/%b want 3/0", estado, magnetron);
    end
    tick(); tick();
    n_checks++;
    if (w_time !== 16'h0042) begin
      n_fail++; $display("FAIL door_hold got %h want 0042", w_time);
    end
    press(0);
    n_checks++;
    if (estado !== 3'd3) begin
      n_fail++; $display("FAIL door_open_start got %0d want 3", estado);
    end
    porta_fechada = 1'b1;
    press(0);
    n_checks++;
    if (estado !== 3'd2 || magnetron !== 1'b1 || w_time !== 16'h0042) begin
      n_fail++; $display("FAIL door_resume got %0d/%b/%h want 2/1/0042", estado, magnetron, w_time);
    end
    tick();
    n_checks++;
    if (w_time !== 16'h0041) begin
      n_fail++; $display("FAIL resume_tick got %h want 0041", w_time);
    end
  endtask

  task automatic test_quick_invalid_simul();
    do_reset();
    key(4'hA);
    n_checks++;
    if (estado !== 3'd0 || w_time !== 16'h0000) begin
      n_fail++; $display("FAIL invalid_key_idle got %0d/%h want 0/0000", estado, w_time);
    end
    press(0);
    n_checks++;
    if (w_time !== 16'h0030 || estado !== 3'd2) begin
      n_fail++; $display("FAIL quick_start got %h/%0d want 0030/2", w_time, estado);
    end
    // Stop and tick arrive together: stop wins, no decrement.
    @(negedge clk100Hz);
    stopn   = 1'b0;
    pgt_1Hz = 1'b1;
    @(negedge clk100Hz);
    stopn   = 1'b1;
    pgt_1Hz = 1'b0;
    @(negedge clk100Hz);
    n_checks++;
    if (estado !== 3'd3 || w_time !== 16'h0030) begin
      n_fail++; $display("FAIL stop_tick got %0d/%h want 3/0030", estado, w_time);
    end
    press(1);
    key(4'd7);
    key(4'hF);
    n_checks++;
    if (estado !== 3'd1 || w_time !== 16'h0007) begin
      n_fail++; $display("FAIL invalid_key_entry got %0d/%h want 1/0007", estado, w_time);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    key(4'd1); key(4'd7);
    press(0);
    @(negedge clk100Hz);
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (estado !== 3'd0 || w_time !== 16'h0000 || magnetron !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got %0d/%h/%b/%b want 0/0000/0/0", estado, w_time, magnetron, done);
    end
    @(negedge clk100Hz);
    resetn = 1'b1;
    @(negedge clk100Hz);
  endtask

  initial begin
    resetn        = 1'b1;
    digito        = 4'd0;
    loadn         = 1'b1;
    pgt_1Hz       = 1'b0;
    startn        = 1'b1;
    stopn         = 1'b1;
    clearn        = 1'b1;
    porta_fechada = 1'b1;
    test_reset();
    test_entry();
    test_cook_done();
    test_borrow();
    test_door();
    test_quick_invalid_simul();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
